// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip adder/subtractor: N bits split into BLOCK_SIZE-bit skip blocks,
// BLOCKS_PER_STAGE blocks resolved per registered stage, valid/ready on both ends.
`timescale 1ns/1ps
module pipelined_carry_skip_adder #(
  parameter int N                = 32,
  parameter int BLOCK_SIZE       = 4,
  parameter int BLOCKS_PER_STAGE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int NUM_BLOCKS = (N + BLOCK_SIZE - 1) / BLOCK_SIZE;
  localparam int STAGES     = (NUM_BLOCKS + BLOCKS_PER_STAGE - 1) / BLOCKS_PER_STAGE;
  localparam int LAST       = STAGES - 1;

  logic [N-1:0] bb;
  logic         c0;

  assign bb = sub ? ~b : b;
  assign c0 = sub | cin;

  logic [STAGES-1:0] valid_r;
  logic [STAGES-1:0] carry_r;
  logic [N-1:0]      a_r   [STAGES];
  logic [N-1:0]      bb_r  [STAGES];
  logic [N-1:0]      sum_r [STAGES];

  logic [STAGES-1:0] in_v;
  logic [STAGES-1:0] op_c;
  logic [STAGES-1:0] nxt_c;
  logic [STAGES-1:0] ready;
  logic [N-1:0]      op_a    [STAGES];
  logic [N-1:0]      op_bb   [STAGES];
  logic [N-1:0]      op_sum  [STAGES];
  logic [N-1:0]      nxt_sum [STAGES];

  // Stage 0 is fed from the ports; every later stage from the registers ahead of it.
  always_comb begin : stage_inputs
    op_a[0]   = a;
    op_bb[0]  = bb;
    op_sum[0] = '0;
    op_c[0]   = c0;
    in_v[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      op_a[k]   = a_r[k-1];
      op_bb[k]  = bb_r[k-1];
      op_sum[k] = sum_r[k-1];
      op_c[k]   = carry_r[k-1];
      in_v[k]   = valid_r[k-1];
    end
  end

  always_comb begin : ready_chain
    logic rdy;
    ready = '0;
    rdy   = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy      = !valid_r[k] || rdy;
      ready[k] = rdy;
    end
  end

  assign in_ready = ready[0];

  // Each block ripples internally; a fully propagating block passes its own carry-in straight on.
  always_comb begin : carry_skip
    logic         c;
    logic         rc;
    logic         p;
    logic         blk_cin;
    logic         x;
    logic [N-1:0] s;
    c       = 1'b0;
    rc      = 1'b0;
    p       = 1'b1;
    blk_cin = 1'b0;
    x       = 1'b0;
    s       = '0;
    nxt_c   = '0;
    for (int k = 0; k < STAGES; k++) begin
      c       = op_c[k];
      s       = op_sum[k];
      rc      = c;
      p       = 1'b1;
      blk_cin = c;
      for (int i = 0; i < N; i++) begin
        if ((i / BLOCK_SIZE) / BLOCKS_PER_STAGE == k) begin
          if (i % BLOCK_SIZE == 0) begin
            blk_cin = c;
            rc      = c;
            p       = 1'b1;
          end
          x    = op_a[k][i] ^ op_bb[k][i];
          s[i] = x ^ rc;
          rc   = (op_a[k][i] & op_bb[k][i]) | (rc & x);
          p    = p & x;
          if ((i % BLOCK_SIZE == BLOCK_SIZE - 1) || (i == N - 1)) begin
            c = p ? blk_cin : rc;
          end
        end
      end
      nxt_sum[k] = s;
      nxt_c[k]   = c;
    end
  end

  // A stage loads whenever it is ready; data only moves when the stage feeding it is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      carry_r <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k]   <= '0;
        bb_r[k]  <= '0;
        sum_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ready[k]) begin
          valid_r[k] <= in_v[k];
          if (in_v[k]) begin
            sum_r[k]   <= nxt_sum[k];
            carry_r[k] <= nxt_c[k];
            a_r[k]     <= op_a[k];
            bb_r[k]    <= op_bb[k];
          end
        end
      end
    end
  end

  assign out_valid = valid_r[LAST];
  assign sum       = sum_r[LAST];
  assign cout      = carry_r[LAST];
  assign overflow  = (a_r[LAST][N-1] == bb_r[LAST][N-1]) && (sum_r[LAST][N-1] != a_r[LAST][N-1]);

endmodule

// File: doc/pipelined_carry_skip_adder.md
# pipelined_carry_skip_adder

Parametrised, pipelined successor to the combinational carry-skip adder. Splits an N-bit add/subtract into BLOCK_SIZE-bit carry-skip blocks and registers every BLOCKS_PER_STAGE blocks. This gives one operation per cycle at a fixed latency, with a valid/ready handshake on both sides. It sits in the benchmarking datapath wherever a wide adder must close timing at higher clock rates and tolerate downstream backpressure.

## Interface
- N, default 32: operand width; must be ≥ 1.
- BLOCK_SIZE, default 4: bits per carry-skip block, 1 ≤ BLOCK_SIZE ≤ N. NUM_BLOCKS = ceil(N/BLOCK_SIZE). The top block is narrower when N is not a multiple of BLOCK_SIZE.
- BLOCKS_PER_STAGE, default 2: blocks resolved per pipeline stage. STAGES = ceil(NUM_BLOCKS/BLOCKS_PER_STAGE).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operation present.
- in_ready  out  1  stage 0 can accept.
- a  in  N  operand A.
- b  in  N  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a+~b+1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- sum  out  N  result.
- cout  out  1  carry out of bit N-1.
- overflow  out  1  two's-complement signed overflow.

## Operation
- Effective operands and carry-in:
  - bb = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
- Each block computes propagate P = &(a_blk ^ bb_blk), ripple sum and ripple carry-out.
  - Carry into the next block = P ? carry_in_blk : ripple_cout.
- Stage k resolves blocks [k·BLOCKS_PER_STAGE, min((k+1)·BLOCKS_PER_STAGE, NUM_BLOCKS)−1] from the carry registered by stage k−1 (stage 0 uses c0).
- Stage k registers:
  - Completed sum bits.
  - Carry into the next unresolved block.
  - Unresolved upper slices of a and bb.
  - The sign bits a[N-1] and bb[N-1].
  - A valid bit.
- The final stage drives sum, cout and overflow.
  - overflow = (a[N-1] == bb[N-1]) && (sum[N-1] != a[N-1]).
- Handshake and stage control:
  - Per-stage advance rule: stage k loads when it is empty or its contents move forward this cycle.
  - Ready chain: ready_k = !valid_k || ready_{k+1}, with ready_STAGES = out_ready. in_ready = ready_0. This is a combinational ready path; no skid buffer.
  - Transfer occurs on the edge where valid && ready are both 1.
  - When a stage's input side is not valid but the stage is ready, its valid bit clears.
  - Stalled stages hold data and valid unchanged.
  - No internal state machine beyond the per-stage valid bits.
- Results leave in acceptance order; nothing is dropped or duplicated.
- Reset (asynchronous assert, any cycle, including mid-stream):
  - All valid bits go to 0 immediately; in-flight operations are discarded.
  - sum, cout and overflow go to 0; out_valid goes to 0.
  - in_ready = 1 while in reset and after release.
- Width rules: all arithmetic is modulo 2^N; cout is the true carry out. For sub=1, cout=1 means no borrow (a ≥ b unsigned).

## Timing
- Latency: an operation accepted at edge t appears with out_valid=1 after edge t+STAGES-1 (STAGES cycles through registers, counting the accept edge's load into stage 0's output), assuming no stalls.
- Throughput: one operation per cycle when out_ready is held high.
- While the pipeline is full with out_ready=0:
  - in_ready = 0.
  - Outputs hold stable; sum, cout and overflow do not change while out_valid=1 and out_ready=0.
- When out_ready rises, all stages advance in the same cycle. in_ready returns high in that same cycle (combinational).
- Data outputs need not be zeroed when out_valid=0, except after reset.
- Stage-0 data inputs are sampled only on accepted edges.

## Test plan
Tests 1–5 use N=8, BLOCK_SIZE=2, BLOCKS_PER_STAGE=1 (STAGES=4).

1. Reset then idle: rst_n low mid-stream with 3 operations in flight → out_valid=0, sum=0, cout=0, overflow=0, in_ready=1; no stale result after release.
2. Full skip chain, a=0xFF, b=0x00, cin=1, sub=0 → sum=0x00, cout=1, overflow=0, 4 cycles after acceptance.
3. Subtract, a=0x05, b=0x07, sub=1 → sum=0xFE, cout=0. Then a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, overflow=1.
4. Back-to-back stream: 16 random ops with out_ready=1 → one result per cycle, in order, matching a+b+cin mod 256.
5. Backpressure: out_ready=0 for 6 cycles while in_valid stays high → exactly 4 ops accepted, in_ready=0, held output stable. Release → all drain in order, none lost or duplicated.
6. Non-divisible width, N=10, BLOCK_SIZE=4, BLOCKS_PER_STAGE=2 (STAGES=2): a=0x3FF, b=0x001, cin=0 → sum=0x000, cout=1, latency 2.
